// File: rtl/panel_pkg.sv
// Shared definitions for the front-panel conditioning block: channel counts,
// button indices, debounce FSM states and the counter sizing helper.
package panel_pkg;

  localparam int NUM_BTN = 8;
  localparam int NUM_SW  = 24;

  localparam int BTN_LOAD  = 0;
  localparam int BTN_LOOK  = 1;
  localparam int BTN_STEP  = 2;
  localparam int BTN_RUN   = 3;
  localparam int BTN_ENTER = 4;
  localparam int BTN_STOP  = 5;
  localparam int BTN_RESET = 6;
  localparam int BTN_DEBUG = 7;

  // Bits [23:16] of the switch bus carry the address, [15:0] the data.
  localparam int SW_ADDR_LSB = 16;

  typedef enum logic {
    DB_IDLE = 1'b0,
    DB_HELD = 1'b1
  } db_state_e;

  // Width of a counter that must hold the largest of three cycle counts.
  function automatic int cnt_width(input int a, input int b, input int c);
    int m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    return (m < 1) ? 1 : $clog2(m + 1);
  endfunction

endpackage

// File: rtl/debounce_btn.sv
// One button channel: two-flop synchroniser, IDLE/HELD debounce FSM with
// registered press/release pulses, and optional auto-repeat while held.
module debounce_btn
  import panel_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 100000,
  parameter bit REPEAT_EN       = 1'b0,
  parameter int REPEAT_DELAY    = 50000000,
  parameter int REPEAT_PERIOD   = 10000000
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic raw_i,
  output logic level_o,
  output logic press_o,
  output logic release_o
);

  localparam int CNT_W = cnt_width(DEBOUNCE_CYCLES, REPEAT_DELAY, REPEAT_PERIOD);
  localparam logic [CNT_W-1:0] DB_LAST        = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] REP_FIRST_LAST = CNT_W'(REPEAT_DELAY - 1);
  localparam logic [CNT_W-1:0] REP_NEXT_LAST  = CNT_W'(REPEAT_PERIOD - 1);

  logic             s1, s2;
  db_state_e        state, state_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic [CNT_W-1:0] rep, rep_nxt;
  logic             rep_first, rep_first_nxt;
  logic             press_nxt, release_nxt;

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // pre-edge values; blocking here would collapse s1/s2 into a single stage.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      s1        <= 1'b0;
      s2        <= 1'b0;
      state     <= DB_IDLE;
      cnt       <= '0;
      rep       <= '0;
      rep_first <= 1'b1;
      press_o   <= 1'b0;
      release_o <= 1'b0;
    end else begin
      s1        <= raw_i;
      s2        <= s1;
      state     <= state_nxt;
      cnt       <= cnt_nxt;
      rep       <= rep_nxt;
      rep_first <= rep_first_nxt;
      press_o   <= press_nxt;
      release_o <= release_nxt;
    end
  end

  // NOTE: every output of this block is given a default first, so no path
  // leaves a signal unassigned and no latch can be inferred.
  always_comb begin
    state_nxt     = state;
    cnt_nxt       = '0;
    rep_nxt       = '0;
    rep_first_nxt = 1'b1;
    press_nxt     = 1'b0;
    release_nxt   = 1'b0;

    case (state)
      DB_IDLE: begin
        if (s2) begin
          if (cnt == DB_LAST) begin
            state_nxt = DB_HELD;
            press_nxt = 1'b1;
          end else begin
            cnt_nxt = cnt + 1'b1;
          end
        end
      end

      DB_HELD: begin
        // An accepted release wins over a coincident repeat, so press and
        // release can never pulse together.
        if (!s2 && cnt == DB_LAST) begin
          state_nxt   = DB_IDLE;
          release_nxt = 1'b1;
        end else begin
          if (!s2) cnt_nxt = cnt + 1'b1;
          if (REPEAT_EN) begin
            rep_first_nxt = rep_first;
            if (rep == (rep_first ? REP_FIRST_LAST : REP_NEXT_LAST)) begin
              press_nxt     = 1'b1;
              rep_nxt       = '0;
              rep_first_nxt = 1'b0;
            end else begin
              rep_nxt = rep + 1'b1;
            end
          end
        end
      end
    endcase
  end

  assign level_o = (state == DB_HELD);

endmodule

// File: rtl/panel_debounce.sv
// Front-panel input conditioner: per-button debounce channels plus an atomic,
// whole-word debounced switch bus with a single-cycle change strobe.
module panel_debounce #(
  parameter int                             NUM_BTN         = panel_pkg::NUM_BTN,
  parameter int                             NUM_SW          = panel_pkg::NUM_SW,
  parameter int                             DEBOUNCE_CYCLES = 100000,
  parameter logic [NUM_BTN-1:0]             REPEAT_MASK     = NUM_BTN'(8'b0000_0100),
  parameter int                             REPEAT_DELAY    = 50000000,
  parameter int                             REPEAT_PERIOD   = 10000000
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic [NUM_BTN-1:0] btn_raw_i,
  input  logic [NUM_SW-1:0]  sw_raw_i,
  output logic [NUM_BTN-1:0] btn_level_o,
  output logic [NUM_BTN-1:0] btn_press_o,
  output logic [NUM_BTN-1:0] btn_release_o,
  output logic [NUM_SW-1:0]  sw_o,
  output logic               sw_change_o
);

  localparam int SW_CNT_W = panel_pkg::cnt_width(DEBOUNCE_CYCLES, 1, 1);
  localparam logic [SW_CNT_W-1:0] SW_LAST = SW_CNT_W'(DEBOUNCE_CYCLES - 1);

  for (genvar i = 0; i < NUM_BTN; i++) begin : g_btn
    debounce_btn #(
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
      .REPEAT_EN       (REPEAT_MASK[i]),
      .REPEAT_DELAY    (REPEAT_DELAY),
      .REPEAT_PERIOD   (REPEAT_PERIOD)
    ) u_btn (
      .clk_i     (clk_i),
      .rst_i     (rst_i),
      .raw_i     (btn_raw_i[i]),
      .level_o   (btn_level_o[i]),
      .press_o   (btn_press_o[i]),
      .release_o (btn_release_o[i])
    );
  end

  logic [NUM_SW-1:0]   sw_s1, sw_s2, sw_cand;
  logic [SW_CNT_W-1:0] sw_cnt;

  // One counter for the whole bus: any bit moving restarts it, so sw_o only
  // ever takes a word that was stable in its entirety.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      sw_s1       <= '0;
      sw_s2       <= '0;
      sw_cand     <= '0;
      sw_cnt      <= '0;
      sw_o        <= '0;
      sw_change_o <= 1'b0;
    end else begin
      sw_s1       <= sw_raw_i;
      sw_s2       <= sw_s1;
      sw_cand     <= sw_s2;
      sw_change_o <= 1'b0;
      if (sw_s2 != sw_cand) begin
        sw_cnt <= '0;
      end else if (sw_cand != sw_o) begin
        if (sw_cnt == SW_LAST) begin
          sw_o        <= sw_cand;
          sw_change_o <= 1'b1;
          sw_cnt      <= '0;
        end else begin
          sw_cnt <= sw_cnt + 1'b1;
        end
      end else begin
        sw_cnt <= '0;
      end
    end
  end

endmodule
